// File: rtl/lsu_rmw.sv
// RV32I load/store unit for a word-addressed memory without byte enables.
// Sub-word stores read the word, merge the new lane(s), and write it back.

module lsu_rmw_lane (
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  input  logic       sel,
  output logic [7:0] merged
);
  assign merged = sel ? new_byte : old_byte;
endmodule

module lsu_rmw #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  // Only the fields still needed after accept are kept.
  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic [15:0] data;
  } req_t;

  state_t      state;
  req_t        req;
  logic        bad;
  logic [31:0] merged;
  logic [31:0] ext;
  logic [31:0] shifted;
  logic [15:0] half;

  // Decode faults from the live request so the accept edge can route it.
  always_comb begin
    bad = 1'b0;
    case (funct3[1:0])
      2'd0:    bad = 1'b0;
      2'd1:    bad = addr[0];
      2'd2:    bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    if (funct3[2] && (is_store || funct3[1])) bad = 1'b1;
    if ({2'b00, addr[31:2]} >= 32'(MEM_WORDS)) bad = 1'b1;
  end

  for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
    localparam logic [1:0] LANE = 2'(b);
    logic       lane_sel;
    logic [7:0] lane_new;
    assign lane_sel = req.funct3[0] ? (req.off[1] == LANE[1]) : (req.off == LANE);
    assign lane_new = req.funct3[0] ? req.data[8*(b%2) +: 8] : req.data[7:0];
    lsu_rmw_lane u_lane (
      .old_byte (mem_rdata[8*b +: 8]),
      .new_byte (lane_new),
      .sel      (lane_sel),
      .merged   (merged[8*b +: 8])
    );
  end

  always_comb begin
    shifted = mem_rdata >> {req.off, 3'b000};
    half    = req.off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (req.funct3)
      3'd0:    ext = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    ext = {{16{half[15]}}, half};
      3'd4:    ext = {24'b0, shifted[7:0]};
      3'd5:    ext = {16'b0, half};
      default: ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      load_data <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
    end else begin
      done      <= 1'b0;
      fault     <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_wdata <= '0;
      case (state)
        IDLE: if (start) begin
          req      <= '{is_store: is_store, funct3: funct3, off: addr[1:0], data: store_data[15:0]};
          mem_addr <= {2'b00, addr[31:2]};
          busy     <= 1'b1;
          if (bad) begin
            state <= DONE;
            done  <= 1'b1;
            fault <= 1'b1;
          end else if (is_store && funct3[1]) begin
            state     <= WRITE;
            mem_write <= 1'b1;
            mem_wdata <= store_data;
          end else begin
            state    <= READ;
            mem_read <= 1'b1;
          end
        end
        READ: begin
          if (req.is_store) begin
            state     <= WRITE;
            mem_write <= 1'b1;
            mem_wdata <= merged;
          end else begin
            state     <= DONE;
            done      <= 1'b1;
            load_data <= ext;
          end
        end
        WRITE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_rmw.sv
// Randomized bench for lsu_rmw: per-cycle expected traces from a word-array
// reference model, plus directed literal cases.

module tb_lsu_rmw;
  localparam int MW = 64;
  localparam int AW = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        busy, done, fault, mem_write, mem_read;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;

  lsu_rmw #(.MEM_WORDS(MW)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .fault(fault), .load_data(load_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [MW];
  logic [31:0] ref_mem [MW];
  logic [31:0] ref_ld = '0;

  always_comb begin
    mem_rdata = '0;
    if (mem_read && mem_addr < MW) mem_rdata = mem[mem_addr[AW-1:0]];
  end

  always @(posedge clk)
    if (mem_write && mem_addr < MW) mem[mem_addr[AW-1:0]] <= mem_wdata;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        busy, done, fault, rd, wr;
    logic [31:0] waddr, wdata, ld;
  } exp_t;

  exp_t q[$];
  exp_t ce;
  bit   chk_en = 1'b0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  logic last_fault = 1'b0;

  always @(posedge clk) if (done) last_fault <= fault;

  always @(negedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
  end

  // Single compare process: one expected record per cycle, idle when none queued.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      if (q.size() > 0) ce = q.pop_front();
      else begin
        ce = '{default: '0};
        ce.ld = ref_ld;
      end
      chk("busy", 32'(busy), 32'(ce.busy));
      chk("done", 32'(done), 32'(ce.done));
      if (ce.done) chk("fault", 32'(fault), 32'(ce.fault));
      chk("mem_read", 32'(mem_read), 32'(ce.rd));
      chk("mem_write", 32'(mem_write), 32'(ce.wr));
      chk("mem_wdata", mem_wdata, ce.wdata);
      chk("load_data", load_data, ce.ld);
      if (ce.rd || ce.wr) chk("mem_addr", mem_addr, ce.waddr);
    end
  end

  function automatic bit mdl_fault(input bit st, input int f3, input logic [31:0] a);
    int size;
    if (st ? (f3 > 2) : (f3 == 3 || f3 > 5)) return 1'b1;
    size = 1 << (f3 % 4);
    if (a % size != 0) return 1'b1;
    if (a / 4 >= MW) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdl_load(input int f3, input logic [31:0] a);
    logic [31:0] v;
    v = ref_mem[a / 4] >> (8 * (a % 4));
    case (f3)
      0: return 32'($signed(v[7:0]));
      1: return 32'($signed(v[15:0]));
      4: return 32'(v[7:0]);
      5: return 32'(v[15:0]);
      default: return v;
    endcase
  endfunction

  task automatic op(input bit st, input int f3, input logic [31:0] a,
                    input logic [31:0] d, input bit spam);
    exp_t x;
    logic [31:0] w, msk;
    int n;
    @(posedge clk); #1;
    start = 1'b1; is_store = st; funct3 = 3'(f3); addr = a; store_data = d;
    rd_cnt = 0; wr_cnt = 0;
    @(posedge clk);
    x = '{default: '0};
    x.busy = 1'b1; x.waddr = a / 4; x.ld = ref_ld;
    if (mdl_fault(st, f3, a)) begin
      x.done = 1'b1; x.fault = 1'b1; q.push_back(x);
    end else if (!st) begin
      x.rd = 1'b1; q.push_back(x);
      ref_ld = mdl_load(f3, a);
      x.rd = 1'b0; x.done = 1'b1; x.ld = ref_ld; q.push_back(x);
    end else begin
      if (f3 == 2) w = d;
      else begin
        msk = ((f3 == 0) ? 32'hFF : 32'hFFFF) << (8 * (a % 4));
        w = (ref_mem[a / 4] & ~msk) | ((d << (8 * (a % 4))) & msk);
        x.rd = 1'b1; q.push_back(x); x.rd = 1'b0;
      end
      x.wr = 1'b1; x.wdata = w; q.push_back(x);
      ref_mem[a / 4] = w;
      x.wr = 1'b0; x.wdata = '0; x.done = 1'b1; q.push_back(x);
    end
    #1 start = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      if (spam) begin
        start = 1'b1; is_store = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom_range(0, 4 * MW - 1); store_data = $urandom;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (q.size() > 0) begin
      chk("drain timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    for (int k = 0; k < MW; k++) begin
      mem[k] = 32'(2 * k);
      ref_mem[k] = 32'(2 * k);
    end
    #2 reset = 1'b1;
    #1;
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst fault", 32'(fault), 0);
    chk("rst rdwr", 32'({mem_read, mem_write}), 0);
    chk("rst load_data", load_data, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk) chk_en = 1'b1;

    op(0, 2, 32'h14, 0, 0);
    chk("lw14 data", load_data, 32'h0000000A);
    chk("lw14 rd cycles", 32'(rd_cnt), 1);
    chk("lw14 fault", 32'(last_fault), 0);

    op(1, 0, 32'h09, 32'hFF, 0);
    chk("sb09 word", mem[2], 32'h0000FF04);
    chk("sb09 rd/wr", 32'(rd_cnt * 16 + wr_cnt), 32'h11);
    op(0, 0, 32'h09, 0, 0);
    chk("lb09", load_data, 32'hFFFFFFFF);
    op(0, 4, 32'h09, 0, 0);
    chk("lbu09", load_data, 32'h000000FF);

    op(1, 1, 32'h0E, 32'h8001, 0);
    chk("sh0e word", mem[3], 32'h80010006);
    op(0, 1, 32'h0E, 0, 0);
    chk("lh0e", load_data, 32'hFFFF8001);
    op(0, 5, 32'h0E, 0, 0);
    chk("lhu0e", load_data, 32'h00008001);
    op(0, 2, 32'h0C, 0, 0);
    chk("lw0c", load_data, 32'h80010006);

    op(0, 2, 32'h02, 0, 0);
    chk("lw02 fault", 32'(last_fault), 1);
    op(0, 1, 32'h07, 0, 0);
    chk("lh07 fault", 32'(last_fault), 1);
    op(0, 2, 32'h100, 0, 0);
    chk("lw100 fault", 32'(last_fault), 1);
    chk("lw100 no mem", 32'(rd_cnt + wr_cnt), 0);
    op(0, 3, 32'h00, 0, 0);
    chk("f3=3 fault", 32'(last_fault), 1);
    chk("fault keeps data", load_data, 32'h80010006);

    // Reset landing in the WRITE cycle of a SW must suppress the write.
    chk_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b1; funct3 = 3'd2; addr = 0; store_data = 32'hDEADBEEF;
    @(posedge clk); #1 start = 1'b0;
    chk("sw in write", 32'(mem_write), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst done", 32'(done), 0);
    chk("mid rst write", 32'(mem_write), 0);
    @(posedge clk); #2 reset = 1'b0;
    ref_ld = '0;
    chk("word0 kept", mem[0], 32'h0);
    @(negedge clk) chk_en = 1'b1;
    op(0, 2, 32'h00, 0, 0);
    chk("lw00 after rst", load_data, 32'h0);

    op(1, 0, 32'h21, 32'h5A, 1);
    chk("spam sb word", mem[8], 32'h00005A10);
    chk("spam single req", 32'(rd_cnt * 16 + wr_cnt), 32'h11);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4 * MW + 7));
      op(1'($urandom), int'($urandom_range(0, 7)), a, $urandom, $urandom_range(0, 3) == 0);
    end

    for (int k = 0; k < MW; k++) chk("final mem", mem[k], ref_mem[k]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
